// File: rtl/mmio_pkg.sv
// mmio_pkg: shared command/status codes, FSM encoding and frame magic for the MMIO scheduler.
package mmio_pkg;
    typedef enum logic [1:0] {CMD_STORE = 2'b00, CMD_FETCH = 2'b01, CMD_QUERY = 2'b10, CMD_RSVD = 2'b11} cmd_e;
    typedef enum logic [1:0] {STS_OK = 2'b00, STS_BUS = 2'b01, STS_TMO = 2'b10, STS_BAD = 2'b11} sts_e;
    typedef enum logic [2:0] {S_IDLE, S_LATCH, S_ISSUE, S_WAIT, S_RESP, S_DONE} state_e;
    localparam logic [31:0] FRAME_MAGIC = "TRAT";
    function automatic logic cmd_bad(input logic [1:0] cmd, input logic dir);
        return (cmd == CMD_RSVD) || (cmd == CMD_STORE && dir) || (cmd == CMD_FETCH && !dir);
    endfunction
endpackage

// File: rtl/mmio_cmd_latch.sv
// mmio_cmd_latch: single-entry command register with valid/ack handshake.
module mmio_cmd_latch #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en_i,
    input  logic         vld_i,
    output logic         ack_o,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] q_q;
    assign ack_o = en_i && vld_i;
    assign q_o   = q_q;
    always_ff @(posedge clock) begin
        if (reset) q_q <= '0;
        else if (ack_o) q_q <= d_i;
    end
endmodule

// File: rtl/mmio_cmd_sched.sv
// mmio_cmd_sched: routes decoded MMIO commands to the APB or AXI engine and posts the response.
// Optional engine-completion timeout enabled by MMIO_SCHED_TIMEOUT_EN.
module mmio_cmd_sched
    import mmio_pkg::*;
#(
    parameter int ADDR     = 28,
    parameter int TMO_BITS = 12
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            cmd_vld_i,
    output logic            cmd_ack_o,
    input  logic            cmd_dir_i,
    input  logic            cmd_apb_i,
    input  logic [1:0]      cmd_cmd_i,
    input  logic [3:0]      cmd_tag_i,
    input  logic [15:0]     cmd_len_i,
    input  logic [3:0]      cmd_lun_i,
    input  logic [ADDR-1:0] cmd_adr_i,
    output logic            mmio_busy_o,
    input  logic            mmio_recv_i,
    output logic            mmio_sent_o,
    output logic            mmio_resp_o,
    output logic            mmio_done_o,
    output logic            apb_req_o,
    input  logic            apb_ack_i,
    input  logic            apb_err_i,
    output logic            axi_req_o,
    input  logic            axi_ack_i,
    input  logic            axi_err_i,
    output logic            req_wr_o,
    output logic [15:0]     req_len_o,
    output logic [ADDR-1:0] req_adr_o,
    output logic            rsp_vld_o,
    input  logic            rsp_rdy_i,
    output logic [3:0]      rsp_tag_o,
    output logic [1:0]      rsp_sts_o
);
    localparam int W = ADDR + 28;
    state_e state_q, state_d;
    logic [1:0] sts_q, sts_d;
    logic [W-1:0] fld;
    logic dir_q, apb_q, eng_ack, eng_err, tmo, req, lun_unused;
    logic [1:0] cmd_q;
    logic [3:0] tag_q, lun_q;
    logic [15:0] len_q;
    logic [ADDR-1:0] adr_q;
    mmio_cmd_latch #(.W(W)) u_latch (
        .clock (clock),
        .reset (reset),
        .en_i  (state_q == S_IDLE),
        .vld_i (cmd_vld_i),
        .ack_o (cmd_ack_o),
        .d_i   ({cmd_dir_i, cmd_apb_i, cmd_cmd_i, cmd_tag_i, cmd_len_i, cmd_lun_i, cmd_adr_i}),
        .q_o   (fld)
    );
    assign {dir_q, apb_q, cmd_q, tag_q, len_q, lun_q, adr_q} = fld;
    assign lun_unused = ^lun_q;
    // Only the engine that was actually requested can complete the command.
    assign eng_ack = apb_q ? apb_ack_i : axi_ack_i;
    assign eng_err = apb_q ? apb_err_i : axi_err_i;
`ifdef MMIO_SCHED_TIMEOUT_EN
    logic [TMO_BITS-1:0] cnt_q;
    always_ff @(posedge clock) begin
        if (reset || state_q != S_ISSUE) cnt_q <= '0;
        else cnt_q <= cnt_q + 1'b1;
    end
    assign tmo = (state_q == S_ISSUE) && (&cnt_q);
`else
    assign tmo = 1'b0;
`endif
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            sts_q   <= STS_OK;
        end else begin
            state_q <= state_d;
            sts_q   <= sts_d;
        end
    end
    always_comb begin
        state_d = state_q;
        sts_d   = sts_q;
        case (state_q)
            S_IDLE:  if (cmd_ack_o) state_d = S_LATCH;
            S_LATCH: if (mmio_recv_i) begin
                state_d = (cmd_bad(cmd_q, dir_q) || cmd_q == CMD_QUERY) ? S_RESP : S_ISSUE;
                sts_d   = cmd_bad(cmd_q, dir_q) ? STS_BAD : STS_OK;
            end
            S_ISSUE: if (tmo) begin
                state_d = S_RESP;
                sts_d   = STS_TMO;
            end else if (eng_ack) begin
                state_d = S_WAIT;
                sts_d   = eng_err ? STS_BUS : STS_OK;
            end
            S_WAIT:  state_d = S_RESP;
            S_RESP:  if (rsp_rdy_i) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end
    assign req         = (state_q == S_ISSUE) && !tmo;
    assign apb_req_o   = req && apb_q;
    assign axi_req_o   = req && !apb_q;
    assign req_wr_o    = (state_q == S_ISSUE) && (cmd_q == CMD_STORE);
    assign req_len_o   = len_q;
    assign req_adr_o   = adr_q;
    assign mmio_busy_o = state_q != S_IDLE;
    assign mmio_sent_o = (state_q == S_WAIT) && (cmd_q == CMD_STORE);
    assign rsp_vld_o   = state_q == S_RESP;
    assign mmio_resp_o = rsp_vld_o && rsp_rdy_i;
    assign mmio_done_o = state_q == S_DONE;
    assign rsp_tag_o   = tag_q;
    assign rsp_sts_o   = sts_q;
endmodule
